// File: rtl/gam_edge_age_engine.sv
// Per-class symmetric edge memory {present, age} with a one-column-per-cycle sweep
// engine for edge update/aging, node clear and class clear, plus single-cycle queries.
module gam_edge_age_engine #(
   parameter int CLASS_COUNT = 10,
   parameter int NODE_COUNT  = 10,
   parameter int AGE_MAX     = 4,
   parameter int PRUNE_EN    = 1,
   parameter int CLS_W       = $clog2(CLASS_COUNT + 1),
   parameter int NODE_W      = $clog2(NODE_COUNT + 1),
   parameter int AGE_W       = $clog2(AGE_MAX + 2),
   parameter int DEG_W       = $clog2(NODE_COUNT + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [1:0]        i_req_op,
   input  logic [CLS_W-1:0]  i_req_cls,
   input  logic [NODE_W-1:0] i_req_s1,
   input  logic [NODE_W-1:0] i_req_s2,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic              o_resp_err,
   output logic              o_resp_present,
   output logic [AGE_W-1:0]  o_resp_age,
   output logic [DEG_W-1:0]  o_resp_degree,
   output logic              o_resp_isolated,
   output logic [DEG_W-1:0]  o_resp_pruned
);

   localparam logic [1:0] OP_UPDATE = 2'd0;
   localparam logic [1:0] OP_CLRNODE = 2'd1;
   localparam logic [1:0] OP_QUERY = 2'd2;
   localparam logic [1:0] OP_CLRCLASS = 2'd3;

   localparam logic [CLS_W-1:0]  CLS_LIM = CLS_W'(CLASS_COUNT);
   localparam logic [NODE_W-1:0] N_LIM   = NODE_W'(NODE_COUNT);
   localparam logic [AGE_W-1:0]  AGE_LIM = AGE_W'(AGE_MAX);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_RESP} state_t;

   state_t            r_state;
   logic [1:0]        r_op;
   logic [CLS_W-1:0]  r_cls;
   logic [NODE_W-1:0] r_s1, r_s2, r_j;
   logic [DEG_W-1:0]  r_deg, r_pruned;
   logic              r_resp_valid, r_resp_err, r_resp_present, r_resp_iso;
   logic [AGE_W-1:0]  r_resp_age;

   logic             r_pres [1:CLASS_COUNT][1:NODE_COUNT][1:NODE_COUNT];
   logic [AGE_W-1:0] r_age  [1:CLASS_COUNT][1:NODE_COUNT][1:NODE_COUNT];

   logic             w_pres, w_prune, w_self, w_tgt, w_last, w_req_err;
   logic             w_cls_ok, w_s1_ok, w_s2_ok;
   logic [AGE_W-1:0] w_age, w_age_inc;
   logic [DEG_W-1:0] w_deg_nxt;

   always_comb begin
      w_cls_ok  = (i_req_cls != '0) && (i_req_cls <= CLS_LIM);
      w_s1_ok   = (i_req_s1 != '0) && (i_req_s1 <= N_LIM);
      w_s2_ok   = (i_req_s2 != '0) && (i_req_s2 <= N_LIM);
      w_req_err = !w_cls_ok || !w_s1_ok
                  || (((i_req_op == OP_UPDATE) || (i_req_op == OP_QUERY)) && !w_s2_ok)
                  || ((i_req_op == OP_UPDATE) && (i_req_s1 == i_req_s2));
   end

   // Sweep datapath: the edge (s1, j) currently under the cursor.
   always_comb begin
      w_pres    = r_pres[r_cls][r_s1][r_j];
      w_age     = r_age[r_cls][r_s1][r_j];
      w_age_inc = (w_age == '1) ? w_age : w_age + 1'b1;
      w_prune   = (PRUNE_EN != 0) && (w_age_inc > AGE_LIM);
      w_self    = (r_j == r_s1);
      w_tgt     = (r_j == r_s2);
      w_last    = (r_j == N_LIM);
      w_deg_nxt = r_deg;
      if ((r_op == OP_UPDATE) && !w_self && (w_tgt || (w_pres && !w_prune)))
         w_deg_nxt = r_deg + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_op           <= OP_UPDATE;
         r_cls          <= '0;
         r_s1           <= '0;
         r_s2           <= '0;
         r_j            <= '0;
         r_deg          <= '0;
         r_pruned       <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_err     <= 1'b0;
         r_resp_present <= 1'b0;
         r_resp_age     <= '0;
         r_resp_iso     <= 1'b0;
         for (int c = 1; c <= CLASS_COUNT; c++)
            for (int a = 1; a <= NODE_COUNT; a++)
               for (int b = 1; b <= NODE_COUNT; b++) begin
                  r_pres[c][a][b] <= 1'b0;
                  r_age[c][a][b]  <= '0;
               end
      end else begin
         case (r_state)
            S_IDLE: if (i_req_valid) begin
               r_op           <= i_req_op;
               r_cls          <= i_req_cls;
               r_s1           <= i_req_s1;
               r_s2           <= i_req_s2;
               r_j            <= NODE_W'(1);
               r_deg          <= '0;
               r_pruned       <= '0;
               r_resp_err     <= 1'b0;
               r_resp_present <= 1'b0;
               r_resp_age     <= '0;
               r_resp_iso     <= 1'b0;
               if (w_req_err) begin
                  r_resp_err   <= 1'b1;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else if (i_req_op == OP_QUERY) begin
                  if (i_req_s1 != i_req_s2) begin
                     r_resp_present <= r_pres[i_req_cls][i_req_s1][i_req_s2];
                     r_resp_age     <= r_age[i_req_cls][i_req_s1][i_req_s2];
                  end
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_state <= S_SWEEP;
               end
            end
            S_SWEEP: begin
               case (r_op)
                  OP_UPDATE: if (!w_self) begin
                     if (w_tgt) begin
                        r_pres[r_cls][r_s1][r_j] <= 1'b1;
                        r_pres[r_cls][r_j][r_s1] <= 1'b1;
                        r_age[r_cls][r_s1][r_j]  <= '0;
                        r_age[r_cls][r_j][r_s1]  <= '0;
                     end else if (w_pres) begin
                        if (w_prune) begin
                           r_pres[r_cls][r_s1][r_j] <= 1'b0;
                           r_pres[r_cls][r_j][r_s1] <= 1'b0;
                           r_age[r_cls][r_s1][r_j]  <= '0;
                           r_age[r_cls][r_j][r_s1]  <= '0;
                           r_pruned <= r_pruned + 1'b1;
                        end else begin
                           r_age[r_cls][r_s1][r_j] <= w_age_inc;
                           r_age[r_cls][r_j][r_s1] <= w_age_inc;
                        end
                     end
                  end
                  OP_CLRNODE: begin
                     r_pres[r_cls][r_s1][r_j] <= 1'b0;
                     r_pres[r_cls][r_j][r_s1] <= 1'b0;
                     r_age[r_cls][r_s1][r_j]  <= '0;
                     r_age[r_cls][r_j][r_s1]  <= '0;
                  end
                  OP_CLRCLASS: begin
                     for (int k = 1; k <= NODE_COUNT; k++) begin
                        r_pres[r_cls][r_j][k] <= 1'b0;
                        r_pres[r_cls][k][r_j] <= 1'b0;
                        r_age[r_cls][r_j][k]  <= '0;
                        r_age[r_cls][k][r_j]  <= '0;
                     end
                  end
                  default: ;
               endcase
               r_deg <= w_deg_nxt;
               if (w_last) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_iso   <= ((r_op == OP_UPDATE) || (r_op == OP_CLRNODE))
                                  && (w_deg_nxt == '0);
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
            S_RESP: if (i_resp_ready) begin
               r_resp_valid <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready     = (r_state == S_IDLE) && !i_rst;
   assign o_resp_valid    = r_resp_valid;
   assign o_resp_err      = r_resp_err;
   assign o_resp_present  = r_resp_present;
   assign o_resp_age      = r_resp_age;
   assign o_resp_degree   = r_deg;
   assign o_resp_isolated = r_resp_iso;
   assign o_resp_pruned   = r_pruned;

endmodule

// File: tb/tb_gam_edge_age_engine.sv
// Directed bench for gam_edge_age_engine: two instances (pruning on/off) driven in
// lockstep, expected responses queued at request time and checked on response.
module tb_gam_edge_age_engine;
   localparam int C = 3, N = 4, AM = 2;
   localparam int CLS_W = 2, NODE_W = 3, AGE_W = 2, DEG_W = 3;
   localparam logic [1:0] UPD = 2'd0, CLN = 2'd1, QRY = 2'd2, CLC = 2'd3;
   localparam int LQ = 1, LS = N + 1;

   logic clk = 1'b0;
   logic rst, req_valid, resp_ready;
   logic [1:0] req_op;
   logic [CLS_W-1:0] req_cls;
   logic [NODE_W-1:0] req_s1, req_s2;
   logic rdy [2], rv [2], err [2], pres [2], iso [2];
   logic [AGE_W-1:0] age [2];
   logic [DEG_W-1:0] deg [2], prn [2];

   always #5 clk = ~clk;

   gam_edge_age_engine #(.CLASS_COUNT(C), .NODE_COUNT(N), .AGE_MAX(AM), .PRUNE_EN(1)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy[0]),
      .i_req_op(req_op), .i_req_cls(req_cls), .i_req_s1(req_s1), .i_req_s2(req_s2),
      .o_resp_valid(rv[0]), .i_resp_ready(resp_ready), .o_resp_err(err[0]),
      .o_resp_present(pres[0]), .o_resp_age(age[0]), .o_resp_degree(deg[0]),
      .o_resp_isolated(iso[0]), .o_resp_pruned(prn[0]));

   gam_edge_age_engine #(.CLASS_COUNT(C), .NODE_COUNT(N), .AGE_MAX(AM), .PRUNE_EN(0)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy[1]),
      .i_req_op(req_op), .i_req_cls(req_cls), .i_req_s1(req_s1), .i_req_s2(req_s2),
      .o_resp_valid(rv[1]), .i_resp_ready(resp_ready), .o_resp_err(err[1]),
      .o_resp_present(pres[1]), .o_resp_age(age[1]), .o_resp_degree(deg[1]),
      .o_resp_isolated(iso[1]), .o_resp_pruned(prn[1]));

   typedef struct {int err; int pres; int age; int deg; int iso; int prn; int lat;} exp_t;
   exp_t q0[$], q1[$];
   int checks = 0, failures = 0;

   function automatic exp_t E(int e_err, int e_pres, int e_age, int e_deg, int e_iso,
                              int e_prn, int e_lat);
      exp_t x;
      x.err = e_err; x.pres = e_pres; x.age = e_age; x.deg = e_deg;
      x.iso = e_iso; x.prn = e_prn; x.lat = e_lat;
      return x;
   endfunction

   task automatic chk(input string tag, input int obs, input int ex);
      checks++;
      assert (obs === ex) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, ex);
      end
   endtask

   // iso < 0 in an expectation means isolation is not defined for that op.
   task automatic do_req(input string tag, input logic [1:0] op, input int cls,
                         input int s1, input int s2, input exp_t e0, input exp_t e1,
                         input int hold);
      exp_t e [2];
      int n;
      q0.push_back(e0);
      q1.push_back(e1);
      @(negedge clk);
      if (hold > 0) resp_ready = 1'b0;
      req_valid = 1'b1; req_op = op;
      req_cls = CLS_W'(cls); req_s1 = NODE_W'(s1); req_s2 = NODE_W'(s2);
      @(posedge clk);
      n = 1;
      @(negedge clk);
      req_valid = 1'b0;
      while (!rv[0] && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      e[0] = q0.pop_front();
      e[1] = q1.pop_front();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s/d%0d/valid", tag, d), int'(rv[d]), 1);
         chk($sformatf("%s/d%0d/lat", tag, d), n, e[d].lat);
         chk($sformatf("%s/d%0d/err", tag, d), int'(err[d]), e[d].err);
         chk($sformatf("%s/d%0d/present", tag, d), int'(pres[d]), e[d].pres);
         chk($sformatf("%s/d%0d/age", tag, d), int'(age[d]), e[d].age);
         chk($sformatf("%s/d%0d/degree", tag, d), int'(deg[d]), e[d].deg);
         chk($sformatf("%s/d%0d/pruned", tag, d), int'(prn[d]), e[d].prn);
         if (e[d].iso >= 0)
            chk($sformatf("%s/d%0d/isolated", tag, d), int'(iso[d]), e[d].iso);
      end
      if (hold > 0) begin
         // A competing request is presented while the response is stalled.
         req_valid = 1'b1; req_op = QRY; req_cls = 2'd3; req_s1 = 3'd2; req_s2 = 3'd1;
         repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
               chk($sformatf("%s/d%0d/hold_valid", tag, d), int'(rv[d]), 1);
               chk($sformatf("%s/d%0d/hold_ready", tag, d), int'(rdy[d]), 0);
               chk($sformatf("%s/d%0d/hold_degree", tag, d), int'(deg[d]), e[d].deg);
               chk($sformatf("%s/d%0d/hold_err", tag, d), int'(err[d]), e[d].err);
               chk($sformatf("%s/d%0d/hold_pruned", tag, d), int'(prn[d]), e[d].prn);
            end
         end
         req_valid = 1'b0;
         resp_ready = 1'b1;
         repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s/post_valid", tag), int'(rv[0] | rv[1]), 0);
         end
         chk($sformatf("%s/post_ready", tag), int'(rdy[0] & rdy[1]), 1);
      end
   endtask

   initial begin
      int seen;
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
      req_op = UPD; req_cls = '0; req_s1 = '0; req_s2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst/ready0", int'(rdy[0]), 0);
      chk("rst/ready1", int'(rdy[1]), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst/resp_valid", int'(rv[0] | rv[1]), 0);
      chk("rst/fields", int'(err[0]) + int'(pres[0]) + int'(age[0]) + int'(deg[0])
                        + int'(iso[0]) + int'(prn[0]), 0);
      chk("rst/ready_after", int'(rdy[0] & rdy[1]), 1);

      do_req("upd12", UPD, 1, 1, 2, E(0,0,0,1,0,0,LS), E(0,0,0,1,0,0,LS), 0);
      do_req("q12", QRY, 1, 1, 2, E(0,1,0,0,-1,0,LQ), E(0,1,0,0,-1,0,LQ), 0);
      do_req("q21", QRY, 1, 2, 1, E(0,1,0,0,-1,0,LQ), E(0,1,0,0,-1,0,LQ), 0);
      do_req("q11", QRY, 1, 1, 1, E(0,0,0,0,-1,0,LQ), E(0,0,0,0,-1,0,LQ), 0);
      do_req("upd13a", UPD, 1, 1, 3, E(0,0,0,2,0,0,LS), E(0,0,0,2,0,0,LS), 0);
      do_req("upd13b", UPD, 1, 1, 3, E(0,0,0,2,0,0,LS), E(0,0,0,2,0,0,LS), 0);
      do_req("upd13c", UPD, 1, 1, 3, E(0,0,0,1,0,1,LS), E(0,0,0,2,0,0,LS), 0);
      do_req("q21_aged", QRY, 1, 2, 1, E(0,0,0,0,-1,0,LQ), E(0,1,3,0,-1,0,LQ), 0);
      do_req("q31", QRY, 1, 3, 1, E(0,1,0,0,-1,0,LQ), E(0,1,0,0,-1,0,LQ), 0);
      do_req("upd13d", UPD, 1, 1, 3, E(0,0,0,1,0,0,LS), E(0,0,0,2,0,0,LS), 0);
      do_req("q12_sat", QRY, 1, 1, 2, E(0,0,0,0,-1,0,LQ), E(0,1,3,0,-1,0,LQ), 0);

      do_req("upd_c2", UPD, 2, 2, 4, E(0,0,0,1,0,0,LS), E(0,0,0,1,0,0,LS), 0);
      do_req("err_cls0", UPD, 0, 1, 2, E(1,0,0,0,-1,0,LQ), E(1,0,0,0,-1,0,LQ), 0);
      do_req("err_s1_5", QRY, 1, 5, 1, E(1,0,0,0,-1,0,LQ), E(1,0,0,0,-1,0,LQ), 0);
      do_req("err_same", UPD, 2, 2, 2, E(1,0,0,0,-1,0,LQ), E(1,0,0,0,-1,0,LQ), 0);
      do_req("err_s2_0", UPD, 1, 1, 0, E(1,0,0,0,-1,0,LQ), E(1,0,0,0,-1,0,LQ), 0);
      do_req("err_cln0", CLN, 1, 0, 1, E(1,0,0,0,-1,0,LQ), E(1,0,0,0,-1,0,LQ), 0);
      do_req("q42_c2", QRY, 2, 4, 2, E(0,1,0,0,-1,0,LQ), E(0,1,0,0,-1,0,LQ), 0);
      do_req("q31_after", QRY, 1, 3, 1, E(0,1,0,0,-1,0,LQ), E(0,1,0,0,-1,0,LQ), 0);

      do_req("clrnode1", CLN, 1, 1, 0, E(0,0,0,0,1,0,LS), E(0,0,0,0,1,0,LS), 0);
      do_req("q31_clr", QRY, 1, 3, 1, E(0,0,0,0,-1,0,LQ), E(0,0,0,0,-1,0,LQ), 0);
      do_req("q21_clr", QRY, 1, 2, 1, E(0,0,0,0,-1,0,LQ), E(0,0,0,0,-1,0,LQ), 0);
      do_req("q24_c2", QRY, 2, 2, 4, E(0,1,0,0,-1,0,LQ), E(0,1,0,0,-1,0,LQ), 0);
      do_req("upd34", UPD, 1, 3, 4, E(0,0,0,1,0,0,LS), E(0,0,0,1,0,0,LS), 0);
      do_req("q43", QRY, 1, 4, 3, E(0,1,0,0,-1,0,LQ), E(0,1,0,0,-1,0,LQ), 0);
      do_req("clrclass1", CLC, 1, 1, 0, E(0,0,0,0,-1,0,LS), E(0,0,0,0,-1,0,LS), 0);
      do_req("q43_cc", QRY, 1, 4, 3, E(0,0,0,0,-1,0,LQ), E(0,0,0,0,-1,0,LQ), 0);
      do_req("q42_cc", QRY, 2, 4, 2, E(0,1,0,0,-1,0,LQ), E(0,1,0,0,-1,0,LQ), 0);

      do_req("bp_upd", UPD, 3, 1, 2, E(0,0,0,1,0,0,LS), E(0,0,0,1,0,0,LS), 3);
      do_req("q21_c3", QRY, 3, 2, 1, E(0,1,0,0,-1,0,LQ), E(0,1,0,0,-1,0,LQ), 0);

      // Reset lands in the middle of an UPDATE sweep.
      @(negedge clk);
      req_valid = 1'b1; req_op = UPD; req_cls = 2'd1; req_s1 = 3'd2; req_s2 = 3'd3;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (rv[0] || rv[1]) seen = 1;
      end
      chk("midrst/no_resp", seen, 0);
      do_req("q24_rst", QRY, 2, 2, 4, E(0,0,0,0,-1,0,LQ), E(0,0,0,0,-1,0,LQ), 0);
      do_req("q21_c3_rst", QRY, 3, 2, 1, E(0,0,0,0,-1,0,LQ), E(0,0,0,0,-1,0,LQ), 0);
      do_req("q32_rst", QRY, 1, 3, 2, E(0,0,0,0,-1,0,LQ), E(0,0,0,0,-1,0,LQ), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
